// File: rtl/rs232tx.sv
// rs232tx: 8N1 serial transmitter behind a small byte FIFO.
//
// Bytes written through the rs232out_w / rs232out_d strobe are queued and
// sent LSB first as start(0), 8 data bits, stop(1). Each bit lasts
// period = frequency / bps clock cycles. Frames leave the FIFO back to back
// with no idle gap between them.
//
// Ports
//   clk            system clock
//   rst            synchronous, active-high reset
//   rs232out_w     write strobe; one byte per cycle, dropped while busy
//   rs232out_d     byte to transmit
//   rs232out_busy  FIFO full (registered)
//   serial_out     TXD line, idle high (registered)
//   tx_idle        FIFO empty and no frame in flight (registered)
module rs232tx #(
  parameter int frequency = 50000000,
  parameter int bps       = 115200,
  parameter int fifo_log2 = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rs232out_w,
  input  logic [7:0] rs232out_d,
  output logic       rs232out_busy,
  output logic       serial_out,
  output logic       tx_idle
);

  localparam int PERIOD = frequency / bps;
  localparam int CW     = $clog2(PERIOD);
  localparam int DEPTH  = 1 << fifo_log2;
  localparam int NW     = fifo_log2 + 1;

  localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]           mem [DEPTH];
  logic [fifo_log2-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0]        count, count_nxt;

  state_t       state;
  logic [CW-1:0] baud;
  logic [2:0]   bit_idx;
  logic [7:0]   shift;

  logic push, pop, fifo_ne, bit_end, to_idle;

  assign fifo_ne = (count != '0);
  assign bit_end = (baud == '0);
  assign push    = rs232out_w && !rs232out_busy;
  // The FSM takes a byte either straight from IDLE or at the last cycle of a
  // stop bit, which is what keeps consecutive frames contiguous.
  assign pop     = fifo_ne && ((state == IDLE) || (state == STOP && bit_end));
  assign to_idle = !fifo_ne && ((state == IDLE) || (state == STOP && bit_end));
  assign count_nxt = count + NW'(push) - NW'(pop);

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= rs232out_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      rs232out_busy <= 1'b0;
      tx_idle       <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      // Status flags are built from post-edge state so they are exact the
      // cycle after any push or pop.
      rs232out_busy <= (count_nxt == NW'(DEPTH));
      tx_idle       <= to_idle && (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      baud       <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      serial_out <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          serial_out <= 1'b1;
          if (fifo_ne) begin
            shift      <= mem[rd_ptr];
            baud       <= RELOAD;
            serial_out <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud       <= RELOAD;
            bit_idx    <= '0;
            serial_out <= shift[0];
            state      <= DATA;
          end else begin
            baud <= baud - 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud <= RELOAD;
            if (bit_idx == 3'd7) begin
              serial_out <= 1'b1;
              state      <= STOP;
            end else begin
              // Next bit is shift[1], which becomes shift[0] after the shift.
              shift      <= shift >> 1;
              serial_out <= shift[1];
              bit_idx    <= bit_idx + 1'b1;
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (fifo_ne) begin
              shift      <= mem[rd_ptr];
              baud       <= RELOAD;
              serial_out <= 1'b0;
              state      <= START;
            end else begin
              serial_out <= 1'b1;
              state      <= IDLE;
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        default: begin
          serial_out <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs232tx.sv
// Directed bench for rs232tx with period = 16 cycles and a 4-entry FIFO.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_rs232tx;

  logic       clk;
  logic       rst;
  logic       rs232out_w;
  logic [7:0] rs232out_d;
  logic       rs232out_busy;
  logic       serial_out;
  logic       tx_idle;

  int errors = 0;
  int checks = 0;

  rs232tx #(.frequency(16), .bps(1), .fifo_log2(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .rs232out_w    (rs232out_w),
    .rs232out_d    (rs232out_d),
    .rs232out_busy (rs232out_busy),
    .serial_out    (serial_out),
    .tx_idle       (tx_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
  endtask

  // Count low cycles on the line over n edges; the line must stay high.
  task automatic expect_quiet(input string tag, input int n);
    int lows;
    int busy_hi;
    lows = 0;
    busy_hi = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (serial_out !== 1'b1) lows++;
      if (tx_idle !== 1'b1) busy_hi++;
    end
    chk({tag, "_line_low_cycles"}, lows, 0);
    chk({tag, "_not_idle_cycles"}, busy_hi, 0);
  endtask

  // Entered just after the edge at cycle offset k0 of a frame whose start
  // bit fell at offset 0; checks every remaining cycle of the frame and
  // returns just after the edge that ends the stop bit (offset 160).
  // Optionally raises a write across that final edge.
  task automatic expect_frame(input string tag, input logic [7:0] b, input int k0,
                              input bit wr_end, input logic [7:0] wd);
    int   bad;
    int   first_bad;
    logic exp_bit;
    logic last_idle;
    bad = 0;
    first_bad = -1;
    last_idle = 1'b1;
    for (int k = k0; k < 160; k++) begin
      if (k < 16)       exp_bit = 1'b0;
      else if (k < 144) exp_bit = b[(k - 16) / 16];
      else              exp_bit = 1'b1;
      if (serial_out !== exp_bit) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
      if (k == 159) begin
        last_idle = tx_idle;
        if (wr_end) begin
          rs232out_w = 1'b1;
          rs232out_d = wd;
        end
      end
      tick();
    end
    rs232out_w = 1'b0;
    chk({tag, "_bad_bit_cycles"}, bad, 0);
    if (bad != 0) $display("  %s first wrong cycle offset %0d", tag, first_bad);
    chk({tag, "_idle_in_stop"}, last_idle, 1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    rs232out_w = 1'b0;
    rs232out_d = 8'h00;

    // Reset
    tick();
    tick();
    chk("rst_serial", serial_out, 1'b1);
    chk("rst_busy", rs232out_busy, 1'b0);
    chk("rst_idle", tx_idle, 1'b1);
    rst = 1'b0;
    expect_quiet("post_reset", 100);

    // Single byte 0x55
    rs232out_w = 1'b1;
    rs232out_d = 8'h55;
    tick();                         // edge N
    rs232out_w = 1'b0;
    chk("b55_idle_after_accept", tx_idle, 1'b0);
    chk("b55_line_still_high", serial_out, 1'b1);
    chk("b55_busy", rs232out_busy, 1'b0);
    tick();                         // edge N+1
    chk("b55_start_falls", serial_out, 1'b0);
    expect_frame("b55", 8'h55, 0, 1'b0, 8'h00);
    chk("b55_idle_after_stop", tx_idle, 1'b1);
    chk("b55_line_after_stop", serial_out, 1'b1);
    expect_quiet("after_b55", 20);

    // Overflow: 0x01..0x06 on six consecutive edges
    rs232out_w = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      rs232out_d = 8'(i);
      tick();
      if (i == 4) chk("ovf_busy_after_4", rs232out_busy, 1'b0);
      if (i == 5) chk("ovf_busy_after_5", rs232out_busy, 1'b1);
    end
    rs232out_w = 1'b0;
    chk("ovf_busy_after_6", rs232out_busy, 1'b1);
    chk("ovf_idle", tx_idle, 1'b0);
    // Frame of 0x01 started at edge 2; we are now 4 edges into it.
    expect_frame("ovf_01", 8'h01, 4, 1'b0, 8'h00);
    chk("ovf_busy_freed", rs232out_busy, 1'b0);
    expect_frame("ovf_02", 8'h02, 0, 1'b0, 8'h00);
    expect_frame("ovf_03", 8'h03, 0, 1'b0, 8'h00);
    expect_frame("ovf_04", 8'h04, 0, 1'b0, 8'h00);
    expect_frame("ovf_05", 8'h05, 0, 1'b0, 8'h00);
    chk("ovf_idle_end", tx_idle, 1'b1);
    expect_quiet("ovf_06_dropped", 200);

    // Back-to-back 0x00 then 0xFF
    rs232out_w = 1'b1;
    rs232out_d = 8'h00;
    tick();
    rs232out_d = 8'hFF;
    tick();                         // 0x00 popped here, 0xFF pushed
    rs232out_w = 1'b0;
    chk("b2b_start_falls", serial_out, 1'b0);
    expect_frame("b2b_00", 8'h00, 0, 1'b0, 8'h00);
    chk("b2b_ff_start_no_gap", serial_out, 1'b0);
    expect_frame("b2b_ff", 8'hFF, 0, 1'b0, 8'h00);
    chk("b2b_idle_end", tx_idle, 1'b1);

    // Reset during data bit 3 of 0xA5 with 0x3C queued
    rs232out_w = 1'b1;
    rs232out_d = 8'hA5;
    tick();
    rs232out_d = 8'h3C;
    tick();                         // 0xA5 starts, 0x3C queued
    rs232out_w = 1'b0;
    for (int i = 0; i < 70; i++) tick();
    chk("mid_bit3_of_a5", serial_out, 1'b0);
    chk("mid_not_idle", tx_idle, 1'b0);
    rst = 1'b1;
    rs232out_w = 1'b1;              // write collides with reset and is lost
    rs232out_d = 8'h81;
    tick();
    rs232out_w = 1'b0;
    chk("mid_rst_serial", serial_out, 1'b1);
    chk("mid_rst_busy", rs232out_busy, 1'b0);
    chk("mid_rst_idle", tx_idle, 1'b1);
    rst = 1'b0;
    expect_quiet("after_mid_rst", 300);

    // Push/pop collision with three entries queued
    rs232out_w = 1'b1;
    rs232out_d = 8'hC3;
    tick();                         // edge N
    rs232out_d = 8'h5A;
    tick();                         // N+1: pop C3, push 5A
    rs232out_d = 8'h0F;
    tick();
    rs232out_d = 8'hF0;
    tick();                         // three entries held
    rs232out_w = 1'b0;
    chk("col_busy_3", rs232out_busy, 1'b0);
    expect_frame("col_c3", 8'hC3, 2, 1'b1, 8'h96);
    chk("col_busy_after", rs232out_busy, 1'b0);
    chk("col_next_start", serial_out, 1'b0);
    expect_frame("col_5a", 8'h5A, 0, 1'b0, 8'h00);
    expect_frame("col_0f", 8'h0F, 0, 1'b0, 8'h00);
    expect_frame("col_f0", 8'hF0, 0, 1'b0, 8'h00);
    expect_frame("col_96", 8'h96, 0, 1'b0, 8'h00);
    chk("col_idle_end", tx_idle, 1'b1);
    expect_quiet("col_tail", 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rs232tx.md
# rs232tx

Serial transmitter on the far side of the `rs232out_w` / `rs232out_d` / `rs232out_busy` handshake driven by the memory-mapped rs232 peripheral. Accepted bytes are buffered in a small FIFO and serialised as 8N1 frames on the board TXD pin. `rs232out_busy` reports "FIFO full", so software that polls busy before each write never loses a byte.

## Interface
- `frequency`, 50000000, clock frequency in Hz.
- `bps`, 115200, line rate; bit period `period = frequency / bps`, truncated; 434 at the defaults; must be >= 2.
- `fifo_log2`, 2, FIFO depth = 2^fifo_log2 = 4 entries.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `rs232out_w`  in  1  write strobe, one byte per cycle.
- `rs232out_d`  in  8  byte to transmit.
- `rs232out_busy`  out  1  FIFO full; registered.
- `serial_out`  out  1  TXD line, idle high; registered.
- `tx_idle`  out  1  FIFO empty and no frame in progress; registered.

## Operation
- Write accept
  - A write is accepted on a rising edge where `rs232out_w` = 1 and `rs232out_busy` = 0. The byte is pushed to the FIFO tail.
  - A write with busy = 1 is silently dropped: no state change, no error indication.
- Busy
  - `rs232out_busy` is a register equal to (count == DEPTH), computed from the post-edge count.
  - Busy is therefore valid on the cycle after each push or pop.
- Simultaneous push and pop on the same edge: both take effect and count is unchanged. A push into a full FIFO cannot happen, because busy gates it.
- Transmit FSM states
  - IDLE: `serial_out` = 1. If the FIFO is non-empty, pop the head into an 8-bit shift register, load the bit counter with `period-1`, drive `serial_out` low, and go to START.
  - START: hold low for `period` cycles, then go to DATA with bit index 0.
  - DATA: drive `shift[0]`, LSB first, for `period` cycles per bit, shifting right after each bit. After bit 7, go to STOP.
  - STOP: drive high for `period` cycles. At the end of STOP:
    - if the FIFO is non-empty, pop and re-enter START directly, so there is no idle cycle between frames;
    - otherwise go to IDLE.
- Frame length is exactly 10·period cycles. Back-to-back frames are contiguous.
- Baud counter counts down from `period-1` to 0; reaching 0 advances the bit. Counter width is clog2(period).
- `tx_idle` = 1 iff the FSM is in IDLE and the FIFO is empty, as registered state.
- FIFO pointers are fifo_log2 bits wide and wrap modulo DEPTH. Count is fifo_log2+1 bits wide.

## Timing
- Reset values: `serial_out` = 1, `rs232out_busy` = 0, `tx_idle` = 1, FIFO empty, FSM in IDLE, shift register 0.
- Reset mid-frame aborts the frame: `serial_out` is 1 after the reset edge and FIFO contents are discarded. A partial frame is tolerated on the line.
- Reset has priority over a same-cycle write; that byte is lost.
- Latency, starting from an empty FIFO and FSM in IDLE:
  - write accepted at edge N, so the byte is in the FIFO after edge N;
  - pop at edge N+1, so `serial_out` falls after edge N+1, and `tx_idle` = 0 after edge N;
  - the stop bit ends at edge N+1+10·period, and `tx_idle` = 1 after that edge if nothing else is queued.
- Because of the early pop, DEPTH+1 consecutive single-cycle writes to an idle transmitter are all accepted.

## Test plan
Benches use `frequency` = 16, `bps` = 1, giving period = 16, and `fifo_log2` = 2.
- Reset: assert `rst` for 2 cycles, then release.
  - Required: `serial_out` = 1, busy = 0, `tx_idle` = 1, and the line stays high for 100 cycles.
- Single byte: write 0x55 at edge N.
  - Required: low during edges N+1..N+16, then bits 1,0,1,0,1,0,1,0 for 16 cycles each, then stop high.
  - Required: `tx_idle` rises after edge N+161.
- Overflow: write 0x01..0x06 on six consecutive edges.
  - Required: busy = 1 after the 5th edge, and 0x06 is dropped.
  - Required: the line carries 0x01..0x05 in order as five contiguous frames (800 cycles); busy returns to 0 after the first pop that frees space.
- Back-to-back extremes: write 0x00 then 0xFF.
  - Required: 0x00 is start + 8 zeros + stop.
  - Required: 0xFF's start bit begins on the cycle immediately after 0x00's stop bit, with no extra high cycle.
- Reset mid-frame: queue 0xA5 and 0x3C, then assert `rst` during data bit 3 of 0xA5.
  - Required: `serial_out` = 1 after the reset edge, busy = 0, `tx_idle` = 1.
  - Required: 0x3C is never transmitted.
- Push/pop collision: FIFO holds 3 entries and a write coincides with a STOP→START pop.
  - Required: count stays 3 and busy stays 0.
